// File: rtl/barrel_shift_pkg.sv
// Shared constants for the pipelined barrel shifter.
// Mode/direction encodings and a constant log2 helper.
package barrel_shift_pkg;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational right-shift level of fixed weight SHIFT.
// Ports: data_i/data_o word, en_i apply, mode_i, fill_i vacated-bit value.
module barrel_shift_level
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] fil;

  assign rot = {data_i[SHIFT-1:0],
                data_i[WIDTH-1:SHIFT]};
  assign fil = {{SHIFT{fill_i}},
                data_i[WIDTH-1:SHIFT]};

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = (mode_i == MODE_ROT) ? rot : fil;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate/logical/arithmetic barrel shifter, valid/ready stream.
// Ports: clk, reset, in_* (valid/ready/data/amt/mode/dir), out_* (valid/ready/data).
module barrel_shifter_pipe
  import barrel_shift_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  REG_EVERY = 1,
  localparam int L         = clog2(WIDTH),
  localparam int P         = (L + REG_EVERY - 1) / REG_EVERY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [L-1:0]     in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [P-1:0]            valid_q;
  logic [P-1:0]            valid_d;
  logic [P-1:0][WIDTH-1:0] data_q;
  logic [P-1:0][L-1:0]     amt_q;
  logic [P-1:0][1:0]       mode_q;
  logic [P-1:0]            dir_q;
  logic [P-1:0]            fill_q;

  logic [P-1:0][WIDTH-1:0] grp_data;
  logic [P-1:0][L-1:0]     grp_amt;
  logic [P-1:0][1:0]       grp_mode;
  logic [P-1:0]            grp_dir;
  logic [P-1:0]            grp_fill;

  logic [P:0]              rdy;
  logic [WIDTH-1:0]        entry_data;
  logic                    entry_fill;

  // Left shifts run through the right shifter
  // in a bit-reversed domain.
  always_comb begin
    entry_data = in_data;
    if (in_dir == DIR_LEFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        entry_data[i] = in_data[WIDTH-1-i];
      end
    end
  end

  // Sign is captured once at entry and
  // carried with the word.
  assign entry_fill = (in_mode == MODE_ASR) &&
                      (in_dir == DIR_RIGHT) &&
                      in_data[WIDTH-1];

  always_comb begin
    rdy    = '0;
    rdy[P] = out_ready;
    for (int j = P - 1; j >= 0; j--) begin
      rdy[j] = ~valid_q[j] | rdy[j+1];
    end
  end

  assign in_ready = rdy[0] & ~reset;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int G = k / REG_EVERY;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    if (k % REG_EVERY == 0) begin : g_head
      assign din = grp_data[G];
    end else begin : g_chain
      assign din = g_lvl[k-1].dout;
    end

    barrel_shift_level #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_level (
      .data_i (din),
      .en_i   (grp_amt[G][k]),
      .mode_i (grp_mode[G]),
      .fill_i (grp_fill[G]),
      .data_o (dout)
    );
  end

  for (genvar j = 0; j < P; j++) begin : g_slice
    localparam int LAST =
      (((j + 1) * REG_EVERY < L) ?
       (j + 1) * REG_EVERY : L) - 1;

    if (j == 0) begin : g_src_in
      assign grp_data[0] = entry_data;
      assign grp_amt[0]  = in_amt;
      assign grp_mode[0] = in_mode;
      assign grp_dir[0]  = in_dir;
      assign grp_fill[0] = entry_fill;
      assign valid_d[0]  = in_valid & in_ready;
    end else begin : g_src_reg
      assign grp_data[j] = data_q[j-1];
      assign grp_amt[j]  = amt_q[j-1];
      assign grp_mode[j] = mode_q[j-1];
      assign grp_dir[j]  = dir_q[j-1];
      assign grp_fill[j] = fill_q[j-1];
      assign valid_d[j]  = valid_q[j-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[j] <= 1'b0;
        data_q[j]  <= '0;
        amt_q[j]   <= '0;
        mode_q[j]  <= '0;
        dir_q[j]   <= 1'b0;
        fill_q[j]  <= 1'b0;
      end else if (rdy[j]) begin
        valid_q[j] <= valid_d[j];
        data_q[j]  <= g_lvl[LAST].dout;
        amt_q[j]   <= grp_amt[j];
        mode_q[j]  <= grp_mode[j];
        dir_q[j]   <= grp_dir[j];
        fill_q[j]  <= grp_fill[j];
      end
    end
  end

  assign out_valid = valid_q[P-1];

  always_comb begin
    out_data = data_q[P-1];
    if (dir_q[P-1] == DIR_LEFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        out_data[i] = data_q[P-1][WIDTH-1-i];
      end
    end
  end

  // The final slice's control fields have
  // no consumer past the last level.
  logic unused_tail;
  assign unused_tail = ^{amt_q[P-1],
                         mode_q[P-1],
                         fill_q[P-1]};

endmodule
